// File: rtl/fp_pkg.sv
// Shared constants and types for the FP32 normalize/round/pack stage.
package fp_pkg;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 2 * BIAS + 1;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam int          FRAC_W  = 23;

    // Result class carried through the pipeline; specials bypass the arithmetic.
    typedef enum logic [1:0] {
        CLS_NUM  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // Normalized operand held between S1 and S2. e is an 11-bit two's complement value.
    typedef struct packed {
        logic              sign;
        logic [10:0]       e;
        logic [FRAC_W-1:0] frac;
        logic              g;
        logic              r;
        logic              s;
        cls_e              cls;
    } s1_t;

endpackage

// File: rtl/fp_norm_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction with guard/round/sticky bits.
module rne_round
    import fp_pkg::*;
(
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_g,
    input  logic              i_r,
    input  logic              i_s,
    input  logic [10:0]       i_e,
    output logic [FRAC_W-1:0] o_frac,
    output logic [10:0]       o_e,
    output logic              o_inexact
);

    logic            w_inc;
    logic [FRAC_W:0] w_sum;

    // Increment on above-half, or exactly half with an odd lsb; a carry-out
    // leaves the fraction at zero and bumps the exponent.
    always_comb begin
        w_inc     = i_g & (i_r | i_s | i_frac[0]);
        w_sum     = {1'b0, i_frac} + {{FRAC_W{1'b0}}, w_inc};
        o_frac    = w_sum[FRAC_W-1:0];
        o_e       = i_e + {10'd0, w_sum[FRAC_W]};
        o_inexact = i_g | i_r | i_s;
    end

endmodule

// File: rtl/fp_norm_round.sv
// FP32 normalize (S1) and round/pack (S2) with a 2-stage valid/ready pipeline.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  e_in,
    input  logic [MANT_W-1:0] m_in,
    input  logic              zero_in,
    input  logic              inf_in,
    input  logic              nan_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       res,
    output logic              ovf,
    output logic              unf,
    output logic              inexact,
    output logic              invalid
);

    localparam logic signed [10:0] E_MAX = 11'(EXP_MAX);

    logic              r_s1_valid;
    s1_t               r_s1;
    logic              r_s2_valid;
    logic [31:0]       r_res;
    logic              r_ovf;
    logic              r_unf;
    logic              r_inexact;
    logic              r_invalid;

    logic              w_s1_advance;
    logic [10:0]       w_e_ext;
    s1_t               w_s1_next;
    logic [FRAC_W-1:0] w_frac_rnd;
    logic [10:0]       w_e_rnd;
    logic              w_inexact_rnd;
    logic [31:0]       w_res;
    logic              w_ovf;
    logic              w_unf;
    logic              w_inexact;
    logic              w_invalid;

    assign w_s1_advance = ~r_s2_valid | out_ready;
    assign in_ready     = ~r_s1_valid | w_s1_advance;
    assign out_valid    = r_s2_valid;
    assign res          = r_res;
    assign ovf          = r_ovf;
    assign unf          = r_unf;
    assign inexact      = r_inexact;
    assign invalid      = r_invalid;

    // S1: align the hidden bit to m[MANT_W-2], extract fraction and G/R/S, classify.
    always_comb begin
        w_e_ext        = {{(11-EXP_W){e_in[EXP_W-1]}}, e_in};
        w_s1_next      = '0;
        w_s1_next.sign = sign_in;
        if (m_in[MANT_W-1]) begin
            // Value in [2,4): shift right; the dropped lsb is covered by the sticky OR.
            w_s1_next.e    = w_e_ext + 11'd1;
            w_s1_next.frac = m_in[MANT_W-2 -: FRAC_W];
            w_s1_next.g    = m_in[MANT_W-2-FRAC_W];
            w_s1_next.r    = m_in[MANT_W-3-FRAC_W];
            w_s1_next.s    = |m_in[MANT_W-4-FRAC_W:0];
        end else if (m_in[MANT_W-2]) begin
            w_s1_next.e    = w_e_ext;
            w_s1_next.frac = m_in[MANT_W-3 -: FRAC_W];
            w_s1_next.g    = m_in[MANT_W-3-FRAC_W];
            w_s1_next.r    = m_in[MANT_W-4-FRAC_W];
            w_s1_next.s    = |m_in[MANT_W-5-FRAC_W:0];
        end else begin
            // Value in [0.5,1): quotient case, shift left by one.
            w_s1_next.e    = w_e_ext - 11'd1;
            w_s1_next.frac = m_in[MANT_W-4 -: FRAC_W];
            w_s1_next.g    = m_in[MANT_W-4-FRAC_W];
            w_s1_next.r    = m_in[MANT_W-5-FRAC_W];
            w_s1_next.s    = |m_in[MANT_W-6-FRAC_W:0];
        end
        if (nan_in)       w_s1_next.cls = CLS_NAN;
        else if (inf_in)  w_s1_next.cls = CLS_INF;
        else if (zero_in) w_s1_next.cls = CLS_ZERO;
        else              w_s1_next.cls = CLS_NUM;
    end

    rne_round u_rne (
        .i_frac    (r_s1.frac),
        .i_g       (r_s1.g),
        .i_r       (r_s1.r),
        .i_s       (r_s1.s),
        .i_e       (r_s1.e),
        .o_frac    (w_frac_rnd),
        .o_e       (w_e_rnd),
        .o_inexact (w_inexact_rnd)
    );

    // S2: range-check the rounded exponent and pack; specials override arithmetic.
    always_comb begin
        w_res     = {r_s1.sign, w_e_rnd[7:0], w_frac_rnd};
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        w_inexact = 1'b0;
        w_invalid = 1'b0;
        case (r_s1.cls)
            CLS_NAN: begin
                w_res     = QNAN;
                w_invalid = 1'b1;
            end
            CLS_INF:  w_res = {r_s1.sign, 8'hFF, 23'h0};
            CLS_ZERO: w_res = {r_s1.sign, 31'h0};
            default: begin
                w_inexact = w_inexact_rnd;
                if ($signed(w_e_rnd) >= E_MAX) begin
                    w_res     = {r_s1.sign, 8'hFF, 23'h0};
                    w_ovf     = 1'b1;
                    w_inexact = 1'b1;
                end else if ($signed(w_e_rnd) <= 11'sd0) begin
                    w_res     = {r_s1.sign, 31'h0};
                    w_unf     = 1'b1;
                    w_inexact = 1'b1;
                end
            end
        endcase
    end

    // Pipeline registers: S1 loads when it can hand off, S2 loads when the consumer frees it.
    always_ff @(posedge clk) begin
        if (arst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            r_s2_valid <= 1'b0;
            r_res      <= 32'h0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inexact  <= 1'b0;
            r_invalid  <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) r_s1 <= w_s1_next;
            end
            if (w_s1_advance) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_res     <= w_res;
                    r_ovf     <= w_ovf;
                    r_unf     <= w_unf;
                    r_inexact <= w_inexact;
                    r_invalid <= w_invalid;
                end
            end
        end
    end

endmodule
